// File: rtl/cpu_run_ctrl_pkg.sv
// Shared types and constants for the CPU run/step controller.
package cpu_run_ctrl_pkg;

  localparam int unsigned SYNC_STAGES = 2;

  typedef enum logic [1:0] {
    ModeRun   = 2'b00,
    ModeStep  = 2'b01,
    ModeBurst = 2'b10,
    ModeHold  = 2'b11
  } mode_e;

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StStep,
    StBurst
  } state_e;

endpackage

// File: rtl/cpu_run_ctrl_btn_debounce.sv
// One button channel: synchroniser, stability counter, debounced level and rising-edge pulse.
module btn_debounce
  import cpu_run_ctrl_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 250000
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_raw,
  output logic btn_level,
  output logic btn_pulse
);

  localparam int unsigned CntW = $clog2(DEBOUNCE_CYCLES + 1);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic [CntW-1:0]        cnt_q, cnt_d;
  logic                   level_q, level_d;
  logic                   pulse_q, pulse_d;
  logic                   sample;

  assign sample = sync_q[SYNC_STAGES-1];

  // The counter only runs while the synchronised sample disagrees with the level.
  always_comb begin
    sync_d  = {sync_q[SYNC_STAGES-2:0], btn_raw};
    cnt_d   = '0;
    level_d = level_q;
    pulse_d = 1'b0;
    if (sample != level_q) begin
      if (cnt_q == CntW'(DEBOUNCE_CYCLES)) begin
        level_d = ~level_q;
        pulse_d = ~level_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    sync_q <= sync_d;
    if (rst) begin
      cnt_q   <= '0;
      level_q <= 1'b0;
      pulse_q <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      level_q <= level_d;
      pulse_q <= pulse_d;
    end
  end

  assign btn_level = level_q;
  assign btn_pulse = pulse_q;

endmodule

// File: rtl/cpu_run_ctrl.sv
// Run/step controller: reset stretcher, button debounce and core clock-enable generation.
// Optional halt_req input is enabled by defining CPU_RUN_CTRL_HALT_EN.
module cpu_run_ctrl
  import cpu_run_ctrl_pkg::*;
#(
  parameter int unsigned RST_STRETCH     = 16,
  parameter int unsigned DEBOUNCE_CYCLES = 250000,
  parameter int unsigned NUM_BTN         = 4,
  parameter int unsigned BURST_W         = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               rstn_pad,
  input  logic [NUM_BTN-1:0] btn_raw,
  input  logic [1:0]         mode,
  input  logic [BURST_W-1:0] burst_len,
`ifdef CPU_RUN_CTRL_HALT_EN
  input  logic               halt_req,
`endif
  output logic               rst_core,
  output logic               cpu_en,
  output logic [NUM_BTN-1:0] btn_level,
  output logic [NUM_BTN-1:0] btn_pulse,
  output logic               busy,
  output logic [31:0]        en_count
);

  logic halt;
`ifdef CPU_RUN_CTRL_HALT_EN
  assign halt = halt_req;
`else
  assign halt = 1'b0;
`endif

  mode_e mode_sel;
  assign mode_sel = mode_e'(mode);

  // Reset stretcher. The pad synchroniser is deliberately not reset by rst.
  logic [SYNC_STAGES-1:0] pad_sync_q, pad_sync_d;
  logic [RST_STRETCH-1:0] sr_q, sr_d;
  logic                   rst_core_q, rst_core_d;

  always_comb begin
    pad_sync_d = {pad_sync_q[SYNC_STAGES-2:0], rstn_pad};
    sr_d       = rst ? '1 : {sr_q[RST_STRETCH-2:0], ~pad_sync_q[SYNC_STAGES-1]};
    rst_core_d = rst | (sr_q != '0);
  end

  always_ff @(posedge clk) begin
    pad_sync_q <= pad_sync_d;
    sr_q       <= sr_d;
    rst_core_q <= rst_core_d;
  end

  assign rst_core = rst_core_q;

  for (genvar i = 0; i < NUM_BTN; i++) begin : g_btn
    btn_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_btn (
      .clk      (clk),
      .rst      (rst),
      .btn_raw  (btn_raw[i]),
      .btn_level(btn_level[i]),
      .btn_pulse(btn_pulse[i])
    );
  end

  // Run-control FSM
  state_e             state_q, state_d;
  logic [BURST_W-1:0] cnt_q, cnt_d;
  logic [31:0]        en_count_q, en_count_d;
  logic               clear;
  logic               trig;

  assign clear = rst | rst_core_q;
  assign trig  = btn_pulse[0];

  always_ff @(posedge clk) begin
    state_q    <= state_d;
    cnt_q      <= cnt_d;
    en_count_q <= en_count_d;
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (clear || halt) begin
      state_d = StIdle;
      cnt_d   = '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (mode_sel == ModeRun) begin
            state_d = StRun;
          end else if (trig && mode_sel == ModeStep) begin
            state_d = StStep;
          end else if (trig && mode_sel == ModeBurst && burst_len != '0) begin
            state_d = StBurst;
            cnt_d   = burst_len;
          end
        end
        StRun: begin
          if (mode_sel != ModeRun) state_d = StIdle;
        end
        StStep: begin
          state_d = StIdle;
        end
        StBurst: begin
          cnt_d = cnt_q - 1'b1;
          if (mode_sel != ModeBurst || cnt_q == BURST_W'(1)) state_d = StIdle;
        end
        default: state_d = StIdle;
      endcase
    end
  end

  always_comb begin
    cpu_en     = (state_q != StIdle);
    busy       = (state_q == StBurst);
    en_count_d = clear ? 32'd0 : en_count_q + {31'd0, cpu_en};
  end

  assign en_count = en_count_q;

endmodule

// File: tb/tb_cpu_run_ctrl.sv
// Self-checking bench for cpu_run_ctrl: directed scenarios plus random traffic against a model.
module tb_cpu_run_ctrl;
  import cpu_run_ctrl_pkg::*;

  localparam int RST_STRETCH = 4;
  localparam int DEB         = 4;
  localparam int NUM_BTN     = 4;
  localparam int BURST_W     = 8;

  logic        clk = 1'b0;
  logic        rst, rstn_pad, halt_req;
  logic [3:0]  btn_raw;
  logic [1:0]  mode;
  logic [7:0]  burst_len;
  logic        rst_core, cpu_en, busy;
  logic [3:0]  btn_level, btn_pulse;
  logic [31:0] en_count;

  always #5 clk = ~clk;

  cpu_run_ctrl #(
    .RST_STRETCH    (RST_STRETCH),
    .DEBOUNCE_CYCLES(DEB),
    .NUM_BTN        (NUM_BTN),
    .BURST_W        (BURST_W)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .rstn_pad (rstn_pad),
    .btn_raw  (btn_raw),
    .mode     (mode),
    .burst_len(burst_len),
`ifdef CPU_RUN_CTRL_HALT_EN
    .halt_req (halt_req),
`endif
    .rst_core (rst_core),
    .cpu_en   (cpu_en),
    .btn_level(btn_level),
    .btn_pulse(btn_pulse),
    .busy     (busy),
    .en_count (en_count)
  );

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: time-history view of the rules.
  bit          m_pad1 = 1'b1, m_pad2 = 1'b1;
  int          m_clean = 0;
  bit          m_rst_core = 1'b1;
  logic [3:0]  m_raw1 = '0, m_raw2 = '0;
  int          m_streak[4] = '{0, 0, 0, 0};
  logic [3:0]  m_level = '0, m_pulse = '0;
  bit          m_running = 0, m_stepping = 0;
  int          m_burst_left = 0;
  logic [31:0] m_count = '0;

  function automatic bit m_en();
    return m_running || m_stepping || (m_burst_left > 0);
  endfunction

  task automatic model_update();
    bit prev_rc = m_rst_core;
    bit prev_p0 = m_pulse[0];
    bit was_en  = m_en();
    m_rst_core = rst || (m_clean < RST_STRETCH);
    if (!rst && m_pad2) m_clean = (m_clean > 1000) ? m_clean : m_clean + 1;
    else m_clean = 0;
    m_pad2 = m_pad1;
    m_pad1 = rstn_pad;
    for (int i = 0; i < NUM_BTN; i++) begin
      m_pulse[i] = 1'b0;
      if (rst) begin
        m_level[i]  = 1'b0;
        m_streak[i] = 0;
      end else if (m_raw2[i] != m_level[i]) begin
        m_streak[i]++;
        if (m_streak[i] == DEB + 1) begin
          m_level[i]  = m_raw2[i];
          m_pulse[i]  = m_raw2[i];
          m_streak[i] = 0;
        end
      end else begin
        m_streak[i] = 0;
      end
    end
    m_raw2 = m_raw1;
    m_raw1 = btn_raw;
    if (rst || prev_rc) m_count = '0;
    else if (was_en) m_count = m_count + 32'd1;
    if (rst || prev_rc || halt_req) begin
      m_running = 0; m_stepping = 0; m_burst_left = 0;
    end else if (m_running) begin
      m_running = (mode == ModeRun);
    end else if (m_stepping) begin
      m_stepping = 0;
    end else if (m_burst_left > 0) begin
      if (mode != ModeBurst) m_burst_left = 0;
      else m_burst_left--;
    end else begin
      if (mode == ModeRun) m_running = 1;
      else if (mode == ModeStep && prev_p0) m_stepping = 1;
      else if (mode == ModeBurst && prev_p0 && burst_len != 8'd0) m_burst_left = int'(burst_len);
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic compare_all();
    chk("rst_core", {31'd0, rst_core}, {31'd0, m_rst_core});
    chk("cpu_en", {31'd0, cpu_en}, {31'd0, m_en()});
    chk("busy", {31'd0, busy}, {31'd0, (m_burst_left > 0)});
    chk("btn_level", {28'd0, btn_level}, {28'd0, m_level});
    chk("btn_pulse", {28'd0, btn_pulse}, {28'd0, m_pulse});
    chk("en_count", en_count, m_count);
  endtask

  task automatic tick();
    @(posedge clk);
    model_update();
    @(negedge clk);
    compare_all();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    repeat (6) tick();
  endtask

  int t_pulse, t_en_first, t_en_last, n_en, n_busy, n_pulse;

  // Press button 0 at the start of the window, release/re-press at the given ticks.
  task automatic press_window(input int n, input int rel_at, input int repress_at);
    t_pulse = -1; t_en_first = -1; t_en_last = -1;
    n_en = 0; n_busy = 0; n_pulse = 0;
    btn_raw[0] = 1'b1;
    for (int i = 1; i <= n; i++) begin
      tick();
      if (btn_pulse[0]) begin
        n_pulse++;
        if (t_pulse < 0) t_pulse = i;
      end
      if (cpu_en) begin
        n_en++;
        if (t_en_first < 0) t_en_first = i;
        t_en_last = i;
      end
      if (busy) n_busy++;
      if (i == rel_at) btn_raw[0] = 1'b0;
      if (i == repress_at) btn_raw[0] = 1'b1;
    end
    btn_raw[0] = 1'b0;
  endtask

  int t_rel, pulses, pad_lo, seen;

  initial begin
    rst = 1'b1; rstn_pad = 1'b1; halt_req = 1'b0;
    btn_raw = '0; mode = ModeHold; burst_len = '0;

    // Power-up
    tick();
    chk("reset_rst_core", {31'd0, rst_core}, 32'd1);
    chk("reset_cpu_en", {31'd0, cpu_en}, 32'd0);
    chk("reset_en_count", en_count, 32'd0);
    tick();
    rst = 1'b0;
    t_rel = -1;
    for (int i = 1; i <= 12; i++) begin
      tick();
      if (!rst_core && t_rel < 0) t_rel = i;
    end
    chk("rst_release_cycles", 32'(t_rel), 32'd5);

    // Bounce on button 0, then hold
    pulses = 0;
    for (int k = 0; k < 4; k++) begin
      btn_raw[0] = (k % 2 == 0);
      repeat (2) begin
        tick();
        if (btn_pulse[0]) pulses++;
      end
    end
    btn_raw[0] = 1'b1;
    t_pulse = -1;
    for (int i = 1; i <= 12; i++) begin
      tick();
      if (btn_pulse[0]) begin
        pulses++;
        if (t_pulse < 0) t_pulse = i;
      end
    end
    chk("bounce_pulse_delay", 32'(t_pulse), 32'd7);
    chk("bounce_pulse_count", 32'(pulses), 32'd1);
    chk("bounce_level", {31'd0, btn_level[0]}, 32'd1);
    btn_raw[0] = 1'b0;
    repeat (12) tick();

    // Single-step
    mode = ModeStep;
    for (int p = 0; p < 3; p++) begin
      press_window(20, 8, 99);
      chk("step_pulse_delay", 32'(t_pulse), 32'd7);
      chk("step_en_latency", 32'(t_en_first - t_pulse), 32'd1);
      chk("step_en_cycles", 32'(n_en), 32'd1);
    end
    chk("step_en_count", en_count, 32'd3);

    // Burst of 5
    mode = ModeBurst; burst_len = 8'd5;
    press_window(20, 8, 99);
    chk("burst5_first", 32'(t_en_first), 32'd8);
    chk("burst5_last", 32'(t_en_last), 32'd12);
    chk("burst5_n_en", 32'(n_en), 32'd5);
    chk("burst5_busy", 32'(n_busy), 32'd5);

    // Burst of 20 with a second press landing mid-burst
    burst_len = 8'd20;
    press_window(40, 8, 14);
    chk("burst20_pulses", 32'(n_pulse), 32'd2);
    chk("burst20_n_en", 32'(n_en), 32'd20);
    chk("burst20_span", 32'(t_en_last - t_en_first + 1), 32'd20);
    repeat (12) tick();

    // Zero-length burst is ignored
    burst_len = 8'd0;
    press_window(20, 8, 99);
    chk("burst0_pulses", 32'(n_pulse), 32'd1);
    chk("burst0_n_en", 32'(n_en), 32'd0);

    // RUN then HOLD
    do_reset();
    mode = ModeRun;
    n_en = 0;
    repeat (10) begin
      tick();
      if (cpu_en) n_en++;
    end
    chk("run_n_en", 32'(n_en), 32'd10);
    mode = ModeHold;
    tick();
    chk("run_abort_en", {31'd0, cpu_en}, 32'd0);
    chk("run_abort_count", en_count, 32'd10);

    // rst in the middle of a long burst
    mode = ModeBurst; burst_len = 8'd200;
    press_window(20, 8, 99);
    chk("rstburst_running", {31'd0, cpu_en}, 32'd1);
    rst = 1'b1;
    tick();
    chk("rstburst_en", {31'd0, cpu_en}, 32'd0);
    chk("rstburst_count", en_count, 32'd0);
    rst = 1'b0;
    repeat (8) tick();
    chk("rstburst_discard", {31'd0, busy}, 32'd0);

`ifdef CPU_RUN_CTRL_HALT_EN
    do_reset();
    mode = ModeBurst; burst_len = 8'd8;
    btn_raw[0] = 1'b1;
    seen = 0;
    for (int i = 0; i < 30 && seen < 4; i++) begin
      tick();
      if (cpu_en) seen++;
    end
    chk("halt_wait", 32'(seen), 32'd4);
    halt_req = 1'b1;
    tick();
    chk("halt_en", {31'd0, cpu_en}, 32'd0);
    chk("halt_busy", {31'd0, busy}, 32'd0);
    chk("halt_count", en_count, 32'd4);
    halt_req = 1'b0;
    btn_raw[0] = 1'b0;
    repeat (12) tick();
    chk("halt_stays_idle", {31'd0, cpu_en}, 32'd0);
`endif

    // Random traffic against the model
    pad_lo = 0;
    for (int c = 0; c < 1500; c++) begin
      if ($urandom_range(24, 0) == 0) mode = 2'($urandom_range(3, 0));
      if ($urandom_range(9, 0) == 0) burst_len = 8'($urandom_range(10, 0));
      for (int i = 0; i < NUM_BTN; i++)
        if ($urandom_range(11, 0) == 0) btn_raw[i] = ~btn_raw[i];
      if (pad_lo > 0) pad_lo--;
      else if ($urandom_range(299, 0) == 0) pad_lo = int'($urandom_range(4, 1));
      rstn_pad = (pad_lo == 0);
      rst = ($urandom_range(399, 0) == 0);
`ifdef CPU_RUN_CTRL_HALT_EN
      halt_req = ($urandom_range(59, 0) == 0);
`endif
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
